// File: rtl/eth_send_top.sv
// rtl/eth_send_top.sv - byte-serial Ethernet-style frame transmitter with LRC-based FCS
module eth_send_top #(
    parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
    parameter logic [47:0] SRC_MAC_ADDR  = 48'h00_0a_95_9d_68_17,
    parameter logic [15:0] MAX_LEN       = 16'd1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [7:0]  pl_data,
    input  logic        pl_vld,
    output logic        pl_rdy,
    output logic [7:0]  out,
    output logic        vld,
    output logic        sof,
    output logic        ready,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        PREAMBLE,
        SFD,
        MACDST,
        MACSRC,
        PLLEN,
        PL,
        FCS,
        ABORT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [15:0] len_q;
    logic [7:0]  lrc;

    logic        gen_vld;
    logic        gen_sof;
    logic        gen_done;
    logic        gen_err;
    logic [7:0]  gen_byte;
    logic        lrc_clr;
    logic        lrc_add;

    // The cycle after the last FCS byte is generated still shows that byte with
    // done, so IDLE is only open for requests once done has cleared.
    assign ready  = (state == IDLE) && !done;
    assign pl_rdy = (state == PL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        gen_vld  = 1'b0;
        gen_sof  = 1'b0;
        gen_done = 1'b0;
        gen_err  = 1'b0;
        gen_byte = 8'h00;
        lrc_clr  = 1'b0;
        lrc_add  = 1'b0;

        case (state)
            IDLE: begin
                // The accept cycle itself generates the first preamble byte, so
                // PREAMBLE only has to produce the remaining six.
                if (ready && start) begin
                    if (len <= MAX_LEN) begin
                        gen_vld  = 1'b1;
                        gen_sof  = 1'b1;
                        gen_byte = 8'hAA;
                        lrc_clr  = 1'b1;
                        state_n  = PREAMBLE;
                    end else begin
                        gen_err = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                gen_vld  = 1'b1;
                gen_byte = 8'hAA;
                if (cnt == 16'd5) state_n = SFD;
            end
            SFD: begin
                gen_vld  = 1'b1;
                gen_byte = 8'hAB;
                state_n  = MACDST;
            end
            MACDST: begin
                gen_vld  = 1'b1;
                lrc_add  = 1'b1;
                gen_byte = DEST_MAC_ADDR[{cnt[2:0], 3'b000} +: 8];
                if (cnt == 16'd5) state_n = MACSRC;
            end
            MACSRC: begin
                gen_vld  = 1'b1;
                lrc_add  = 1'b1;
                gen_byte = SRC_MAC_ADDR[{cnt[2:0], 3'b000} +: 8];
                if (cnt == 16'd5) state_n = PLLEN;
            end
            PLLEN: begin
                gen_vld  = 1'b1;
                lrc_add  = 1'b1;
                gen_byte = (cnt == 16'd0) ? len_q[15:8] : len_q[7:0];
                if (cnt == 16'd1) state_n = (len_q == 16'd0) ? FCS : PL;
            end
            PL: begin
                if (pl_vld) begin
                    gen_vld  = 1'b1;
                    lrc_add  = 1'b1;
                    gen_byte = pl_data;
                    if (cnt == len_q - 16'd1) state_n = FCS;
                end else begin
                    gen_err = 1'b1;
                    state_n = ABORT;
                end
            end
            FCS: begin
                gen_vld  = 1'b1;
                gen_byte = ~lrc + 8'd1;
                if (cnt == 16'd3) begin
                    gen_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            ABORT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        cnt_n = (state_n != state) ? 16'd0 : cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= 8'h00;
            vld   <= 1'b0;
            sof   <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            lrc   <= 8'h00;
            len_q <= 16'd0;
        end else begin
            out  <= gen_vld ? gen_byte : 8'h00;
            vld  <= gen_vld;
            sof  <= gen_sof;
            done <= gen_done;
            err  <= gen_err;
            if (lrc_clr) begin
                lrc   <= 8'h00;
                len_q <= len;
            end else if (lrc_add) begin
                lrc <= lrc + gen_byte;
            end
        end
    end

endmodule

// File: tb/tb_eth_send_top.sv
// tb/tb_eth_send_top.sv - cycle-table bench for eth_send_top against a frame-level model
module tb_eth_send_top;

    localparam int NC = 280;
    localparam logic [47:0] DEST = 48'h00_0a_95_9d_68_16;
    localparam logic [47:0] SRC  = 48'h00_0a_95_9d_68_17;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [7:0]  pl_data;
    logic        pl_vld;
    logic        pl_rdy;
    logic [7:0]  out;
    logic        vld;
    logic        sof;
    logic        ready;
    logic        done;
    logic        err;

    eth_send_top dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .pl_data (pl_data),
        .pl_vld  (pl_vld),
        .pl_rdy  (pl_rdy),
        .out     (out),
        .vld     (vld),
        .sof     (sof),
        .ready   (ready),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // expected outputs and driven inputs, indexed by cycle number
    logic [7:0]  e_out   [NC];
    logic        e_vld   [NC];
    logic        e_sof   [NC];
    logic        e_done  [NC];
    logic        e_err   [NC];
    logic        e_ready [NC];
    logic        e_plr   [NC];
    logic        chk     [NC];
    logic        d_rst   [NC];
    logic        d_start [NC];
    logic [15:0] d_len   [NC];
    logic        d_plv   [NC];
    logic [7:0]  d_pld   [NC];

    logic [7:0]  fb  [0:63];
    logic [7:0]  pay [0:15];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame as the receiver sees it: header, length, payload, then the byte that
    // makes the sum of everything from the destination MAC onward zero mod 256.
    function automatic int build_frame(input int n);
        int          sum;
        logic [15:0] nl;
        logic [7:0]  f;
        nl = 16'(n);
        for (int i = 0; i < 7; i++) fb[i] = 8'hAA;
        fb[7] = 8'hAB;
        for (int k = 0; k < 6; k++) begin
            fb[8 + k]  = DEST[8*k +: 8];
            fb[14 + k] = SRC[8*k +: 8];
        end
        fb[20] = nl[15:8];
        fb[21] = nl[7:0];
        for (int j = 0; j < n; j++) fb[22 + j] = pay[j];
        sum = 0;
        for (int i = 8; i < 22 + n; i++) sum += int'(fb[i]);
        f = 8'((256 - (sum % 256)) % 256);
        for (int i = 0; i < 4; i++) fb[22 + n + i] = f;
        return 26 + n;
    endfunction

    task automatic set_idle(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            e_out[c]   = 8'h00;
            e_vld[c]   = 1'b0;
            e_sof[c]   = 1'b0;
            e_done[c]  = 1'b0;
            e_err[c]   = 1'b0;
            e_ready[c] = 1'b1;
            e_plr[c]   = 1'b0;
        end
    endtask

    // k < 0: complete frame; otherwise upstream goes empty on payload cycle k
    task automatic plan_frame(input int t, input int n, input int k);
        int nb;
        nb = build_frame(n);
        d_start[t] = 1'b1;
        d_len[t]   = 16'(n);
        for (int j = 0; j < n; j++) d_pld[t + 22 + j] = pay[j];
        e_sof[t + 1] = 1'b1;
        if (k < 0) begin
            for (int i = 0; i < nb; i++) begin
                e_vld[t + 1 + i] = 1'b1;
                e_out[t + 1 + i] = fb[i];
            end
            for (int c = t + 1; c <= t + nb; c++) e_ready[c] = 1'b0;
            e_done[t + nb] = 1'b1;
            for (int j = 0; j < n; j++) e_plr[t + 22 + j] = 1'b1;
        end else begin
            for (int i = 0; i < 22 + k; i++) begin
                e_vld[t + 1 + i] = 1'b1;
                e_out[t + 1 + i] = fb[i];
            end
            for (int c = t + 1; c <= t + 23 + k; c++) e_ready[c] = 1'b0;
            for (int j = 0; j <= k; j++) e_plr[t + 22 + j] = 1'b1;
            d_plv[t + 22 + k] = 1'b0;
            e_err[t + 23 + k] = 1'b1;
        end
    endtask

    task automatic apply(input int c);
        rst     = d_rst[c];
        start   = d_start[c];
        len     = d_len[c];
        pl_vld  = d_plv[c];
        pl_data = d_pld[c];
    endtask

    task automatic pin(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [13:0] a;
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (cyc < NC && chk[cyc]) begin
                a = {vld, sof, done, err, ready, pl_rdy, out};
                e = {e_vld[cyc], e_sof[cyc], e_done[cyc], e_err[cyc], e_ready[cyc], e_plr[cyc], e_out[cyc]};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got vld=%b sof=%b done=%b err=%b ready=%b pl_rdy=%b out=%h, expected vld=%b sof=%b done=%b err=%b ready=%b pl_rdy=%b out=%h",
                             cyc, a[13], a[12], a[11], a[10], a[9], a[8], a[7:0],
                             e[13], e[12], e[11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        int nb;
        set_idle(0, NC - 1);
        for (int c = 0; c < NC; c++) begin
            chk[c]     = (c >= 1);
            d_rst[c]   = (c <= 2);
            d_start[c] = 1'b0;
            d_len[c]   = 16'd3;
            d_plv[c]   = 1'b1;
            d_pld[c]   = 8'hEE;
        end

        // pin the model to the hand-computed frames
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        nb = build_frame(3);
        pin("len3 byte count", nb, 29);
        pin("len3 first dst byte", int'(fb[8]), 'h16);
        pin("len3 last dst byte", int'(fb[13]), 'h00);
        pin("len3 first src byte", int'(fb[14]), 'h17);
        pin("len3 len low byte", int'(fb[21]), 'h03);
        pin("len3 fcs", int'(fb[28]), 'h82);
        nb = build_frame(0);
        pin("len0 byte count", nb, 26);
        pin("len0 fcs", int'(fb[25]), 'h8B);

        // normal frame, len=3
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        plan_frame(5, 3, -1);
        // empty payload
        plan_frame(40, 0, -1);
        // underrun on the third payload cycle of a len=4 frame
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        plan_frame(70, 4, 2);
        // oversize request rejected, then a len=1 frame
        d_start[100] = 1'b1;
        d_len[100]   = 16'd1501;
        e_err[101]   = 1'b1;
        pay[0] = 8'h5A;
        plan_frame(103, 1, -1);
        // reset while MACSRC bytes are being generated, then a clean len=3 frame
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        plan_frame(135, 3, -1);
        d_rst[151] = 1'b1;
        set_idle(152, 164);
        plan_frame(155, 3, -1);
        // start held high across two back-to-back frames
        plan_frame(190, 3, -1);
        plan_frame(220, 3, -1);
        for (int c = 190; c <= 220; c++) begin
            d_start[c] = 1'b1;
            d_len[c]   = 16'd3;
        end

        apply(0);
        for (int c = 1; c < 270; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            apply(c);
        end
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
